sdpram_bw: RTL and testbench
============================

Name: sdpram_bw

Overview:
- Parametrised single-clock simple dual-port RAM: one write port, one read port.
- Adds per-byte write enables, configurable read latency (1–3) with a read-valid strobe, a selectable collision mode, and out-of-range address protection.
- Generic storage primitive for caches, queues and register-file shadows across the design.
- Synthesisable behavioural array; no vendor macro.

Parameters:
- DATA_DEPTH, 256, number of words; need not be a power of two.
- DATA_WIDTH, 32, word width in bits; must be a multiple of BYTE_WIDTH.
- BYTE_WIDTH, 8, bits per write-enable lane.
- READ_LATENCY, 1, cycles from read request to data; legal range 1..3.
- WRITE_MODE, sdpram_pkg::WM_WRITE_FIRST, same-address collision policy: WM_WRITE_FIRST or WM_READ_FIRST.
- Localparam ADDR_WIDTH = max(1, $clog2(DATA_DEPTH)).
- Localparam NB_BYTES = DATA_WIDTH / BYTE_WIDTH.

Ports:
- clk  input  1  single clock for both ports.
- rst  input  1  synchronous, active-high reset.
- wr_en_i  input  1  write request.
- wr_be_i  input  NB_BYTES  byte enables; bit k writes bits [k*BYTE_WIDTH +: BYTE_WIDTH].
- wr_addr_i  input  ADDR_WIDTH  write address.
- wr_data_i  input  DATA_WIDTH  write data.
- rd_en_i  input  1  read request.
- rd_addr_i  input  ADDR_WIDTH  read address.
- rd_data_o  output  DATA_WIDTH  read data.
- rd_valid_o  output  1  one-cycle strobe; rd_data_o is valid when high.
- rd_perr_o  output  1  parity error flag for the returned word.

Behaviour:
- Elaboration-time errors:
  - DATA_WIDTH % BYTE_WIDTH != 0.
  - READ_LATENCY outside 1..3.
- Reset:
  - rd_data_o = 0, rd_valid_o = 0, rd_perr_o = 0.
  - All read-pipeline stages and their valid bits cleared.
  - Memory array not cleared.
  - While rst is high, writes and reads are ignored.
- Write:
  - On posedge clk with wr_en_i=1 and rst=0, each byte lane with wr_be_i[k]=1 is updated.
  - Lanes with wr_be_i[k]=0 keep their old value.
  - wr_be_i = 0 is a no-op.
- Read:
  - A request accepted at edge N returns data with rd_valid_o=1 during the cycle after edge N+READ_LATENCY-1; i.e. latency is READ_LATENCY cycles.
  - Stage 1 is the array read register; stages 2..3 are plain pipeline registers.
  - Back-to-back reads sustain one word per cycle.
- Hold: when no valid word arrives at the last stage, rd_data_o holds its previous value and rd_valid_o=0.
- Collision (same address, same edge, both enables high):
  - WM_WRITE_FIRST: enabled lanes return wr_data_i; disabled lanes return the old array contents.
  - WM_READ_FIRST: the full old word is returned.
- Write to an address whose read is still in stages 2..3: no effect on the in-flight data. Data is captured at stage 1.
- Out of range (address >= DATA_DEPTH, non-power-of-two depth only):
  - Write is dropped.
  - Read still produces rd_valid_o with rd_data_o = 0.
- Reset mid-operation: in-flight reads are discarded and no rd_valid_o is produced for them. Writes on the same edge as rst are dropped.

Optional Feature:
- Macro SDPRAM_PARITY_EN.
- Defined:
  - One even-parity bit stored per byte lane, written alongside the data.
  - On read, parity is recomputed per lane at stage 1 and OR-reduced.
  - The result travels with the data pipeline; rd_perr_o is asserted coincident with rd_valid_o.
  - Write-first bypass lanes take freshly computed parity.
  - Out-of-range reads report rd_perr_o=0.
- Undefined: no parity storage; rd_perr_o tied to 0.

Decomposition:
- Package sdpram_pkg holds:
  - typedef enum write_mode_e {WM_WRITE_FIRST, WM_READ_FIRST}.
  - function byte_parity(word, nb_bytes).
  - constant SDPRAM_MAX_READ_LATENCY = 3.
- Sub-module sdpram_rd_pipe:
  - Parametrised delay line of (data, perr, valid) with depth READ_LATENCY-1.
  - Reset clears the valid bits and output data.
  - The top level contains the array, collision mux and stage-1 register.

Test Plan:
- Reset then idle: rd_valid_o=0 and rd_data_o=0 for 10 cycles, for each READ_LATENCY in {1,2,3}.
- Write 0xDEADBEEF to addr 5 with be=4'b1111, then write 0x11223344 to addr 5 with be=4'b0101, then read addr 5 → 0xDE22BE44, valid exactly READ_LATENCY cycles after the request.
- Collision, addr 7 holds 0xAAAAAAAA; write 0x55555555 with be=4'b0011 while reading addr 7:
  - WM_WRITE_FIRST → 0xAAAA5555.
  - WM_READ_FIRST → 0xAAAAAAAA.
- DATA_DEPTH=200: write addr 210 then read addr 210 → rd_valid_o=1, rd_data_o=0; read addr 199 is unaffected.
- READ_LATENCY=3: 8 back-to-back reads of addrs 0..7 holding i*3 → 8 consecutive valid cycles returning 0,3,...,21. Assert rst on the 4th return cycle → no further rd_valid_o, outputs 0.
- SDPRAM_PARITY_EN: force-flip one stored bit at addr 9 via hierarchical deposit, then read addr 9 → rd_perr_o=1 with rd_valid_o. A clean read of addr 10 → rd_perr_o=0.

Source files
------------

// File: rtl/sdpram_pkg.sv
// Shared types and helpers for the simple dual-port byte-write RAM.
package sdpram_pkg;

  typedef enum logic {
    WM_WRITE_FIRST,
    WM_READ_FIRST
  } write_mode_e;

  localparam int unsigned SDPRAM_MAX_READ_LATENCY = 3;
  localparam int unsigned SDPRAM_MAX_WIDTH        = 1024;
  localparam int unsigned SDPRAM_MAX_BYTES        = 128;

  // Even parity per lane: bit k is the XOR of lane k, so lane plus parity has even weight.
  function automatic logic [SDPRAM_MAX_BYTES-1:0] byte_parity(
    input logic [SDPRAM_MAX_WIDTH-1:0] word,
    input int unsigned                 nb_bytes,
    input int unsigned                 byte_width = 8
  );
    logic [SDPRAM_MAX_BYTES-1:0] par;
    par = '0;
    for (int unsigned k = 0; k < nb_bytes; k++) begin
      for (int unsigned b = 0; b < byte_width; b++) begin
        par[k] = par[k] ^ word[k*byte_width + b];
      end
    end
    return par;
  endfunction

endpackage

// File: rtl/sdpram_rd_pipe.sv
// Delay line for (data, perr, valid) behind the array read register; data holds when no word arrives.
module sdpram_rd_pipe #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned DEPTH      = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] in_data_i,
  input  logic                  in_perr_i,
  input  logic                  in_valid_i,
  output logic [DATA_WIDTH-1:0] out_data_o,
  output logic                  out_perr_o,
  output logic                  out_valid_o
);

  logic [DATA_WIDTH-1:0] data_q [DEPTH];
  logic [DATA_WIDTH-1:0] data_d [DEPTH];
  logic [DEPTH-1:0]      valid_q, valid_d;
  logic [DEPTH-1:0]      perr_q, perr_d;

  always_comb begin
    valid_d    = '0;
    perr_d     = '0;
    valid_d[0] = in_valid_i;
    perr_d[0]  = in_valid_i & in_perr_i;
    data_d[0]  = in_valid_i ? in_data_i : data_q[0];
    for (int unsigned s = 1; s < DEPTH; s++) begin
      valid_d[s] = valid_q[s-1];
      perr_d[s]  = valid_q[s-1] & perr_q[s-1];
      data_d[s]  = valid_q[s-1] ? data_q[s-1] : data_q[s];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
      perr_q  <= '0;
      for (int unsigned s = 0; s < DEPTH; s++) begin
        data_q[s] <= '0;
      end
    end else begin
      valid_q <= valid_d;
      perr_q  <= perr_d;
      data_q  <= data_d;
    end
  end

  assign out_data_o  = data_q[DEPTH-1];
  assign out_perr_o  = perr_q[DEPTH-1];
  assign out_valid_o = valid_q[DEPTH-1];

endmodule

// File: rtl/sdpram_bw.sv
// Simple dual-port RAM with byte enables, 1..3 cycle read latency and collision policy.
// Define SDPRAM_PARITY_EN to store one even-parity bit per byte lane and report rd_perr_o.
module sdpram_bw
  import sdpram_pkg::*;
#(
  parameter int unsigned DATA_DEPTH   = 256,
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned BYTE_WIDTH   = 8,
  parameter int unsigned READ_LATENCY = 1,
  parameter write_mode_e WRITE_MODE   = WM_WRITE_FIRST,
  localparam int unsigned ADDR_WIDTH  = (DATA_DEPTH > 1) ? $clog2(DATA_DEPTH) : 1,
  localparam int unsigned NB_BYTES    = DATA_WIDTH / BYTE_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en_i,
  input  logic [NB_BYTES-1:0]   wr_be_i,
  input  logic [ADDR_WIDTH-1:0] wr_addr_i,
  input  logic [DATA_WIDTH-1:0] wr_data_i,
  input  logic                  rd_en_i,
  input  logic [ADDR_WIDTH-1:0] rd_addr_i,
  output logic [DATA_WIDTH-1:0] rd_data_o,
  output logic                  rd_valid_o,
  output logic                  rd_perr_o
);

  if (DATA_WIDTH % BYTE_WIDTH != 0) begin : g_err_width
    $error("sdpram_bw: DATA_WIDTH must be a multiple of BYTE_WIDTH");
  end
  if (READ_LATENCY < 1 || READ_LATENCY > SDPRAM_MAX_READ_LATENCY) begin : g_err_latency
    $error("sdpram_bw: READ_LATENCY must be within 1..3");
  end

  logic [DATA_WIDTH-1:0] mem_q [DATA_DEPTH];

  logic                  wr_in_range, rd_in_range, wr_fire, rd_fire;
  logic [NB_BYTES-1:0]   bypass;
  logic [DATA_WIDTH-1:0] rd_word;
  logic                  rd_perr;
  logic [DATA_WIDTH-1:0] s1_data_q, s1_data_d;
  logic                  s1_valid_q, s1_valid_d, s1_perr_q, s1_perr_d;

  assign wr_in_range = 32'(wr_addr_i) < DATA_DEPTH;
  assign rd_in_range = 32'(rd_addr_i) < DATA_DEPTH;
  assign wr_fire     = wr_en_i & ~rst & wr_in_range;
  assign rd_fire     = rd_en_i & ~rst;
  // Lanes being written this edge to the address being read are forwarded in write-first mode.
  assign bypass = (WRITE_MODE == WM_WRITE_FIRST && wr_fire && wr_addr_i == rd_addr_i) ?
                  wr_be_i : '0;

  always_ff @(posedge clk) begin
    if (wr_fire) begin
      for (int unsigned k = 0; k < NB_BYTES; k++) begin
        if (wr_be_i[k]) begin
          mem_q[wr_addr_i][k*BYTE_WIDTH +: BYTE_WIDTH] <= wr_data_i[k*BYTE_WIDTH +: BYTE_WIDTH];
        end
      end
    end
  end

  always_comb begin
    rd_word = mem_q[rd_addr_i];
    for (int unsigned k = 0; k < NB_BYTES; k++) begin
      if (bypass[k]) begin
        rd_word[k*BYTE_WIDTH +: BYTE_WIDTH] = wr_data_i[k*BYTE_WIDTH +: BYTE_WIDTH];
      end
    end
    if (!rd_in_range) begin
      rd_word = '0;
    end
  end

`ifdef SDPRAM_PARITY_EN
  logic [NB_BYTES-1:0] par_q [DATA_DEPTH];
  logic [NB_BYTES-1:0] wr_par, rd_par, rd_chk;

  assign wr_par = NB_BYTES'(byte_parity(SDPRAM_MAX_WIDTH'(wr_data_i), NB_BYTES, BYTE_WIDTH));
  assign rd_chk = NB_BYTES'(byte_parity(SDPRAM_MAX_WIDTH'(rd_word), NB_BYTES, BYTE_WIDTH));

  always_ff @(posedge clk) begin
    if (wr_fire) begin
      for (int unsigned k = 0; k < NB_BYTES; k++) begin
        if (wr_be_i[k]) begin
          par_q[wr_addr_i][k] <= wr_par[k];
        end
      end
    end
  end

  always_comb begin
    rd_par  = (par_q[rd_addr_i] & ~bypass) | (wr_par & bypass);
    rd_perr = rd_in_range && (rd_chk != rd_par);
  end
`else
  assign rd_perr = 1'b0;
`endif

  always_comb begin
    s1_valid_d = rd_fire;
    s1_data_d  = rd_fire ? rd_word : s1_data_q;
    s1_perr_d  = rd_fire & rd_perr;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_perr_q  <= 1'b0;
      s1_data_q  <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_perr_q  <= s1_perr_d;
      s1_data_q  <= s1_data_d;
    end
  end

  if (READ_LATENCY == 1) begin : g_lat1
    assign rd_data_o  = s1_data_q;
    assign rd_valid_o = s1_valid_q;
    assign rd_perr_o  = s1_perr_q;
  end else begin : g_pipe
    sdpram_rd_pipe #(
      .DATA_WIDTH (DATA_WIDTH),
      .DEPTH      (READ_LATENCY - 1)
    ) u_rd_pipe (
      .clk         (clk),
      .rst         (rst),
      .in_data_i   (s1_data_q),
      .in_perr_i   (s1_perr_q),
      .in_valid_i  (s1_valid_q),
      .out_data_o  (rd_data_o),
      .out_perr_o  (rd_perr_o),
      .out_valid_o (rd_valid_o)
    );
  end

endmodule

// File: tb/tb_sdpram_bw.sv
// Bench for sdpram_bw: three configurations share one stimulus stream against a cycle-scheduled model.
// Define SDPRAM_PARITY_EN to add the parity-corruption scenario.
module tb_sdpram_bw;
  import sdpram_pkg::*;

  localparam int NI = 3;
  localparam int NC = 1024;
  localparam int RLS [NI] = '{1, 2, 3};
  localparam int DEP [NI] = '{256, 256, 200};
  localparam bit RDF [NI] = '{1'b0, 1'b1, 1'b0};
`ifdef SDPRAM_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        wr_en = 1'b0, rd_en = 1'b0;
  logic [3:0]  wr_be = '0;
  logic [7:0]  wr_addr = '0, rd_addr = '0;
  logic [31:0] wr_data = '0;
  logic [31:0] dd [NI];
  logic        vv [NI];
  logic        pp [NI];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  sdpram_bw #(.DATA_DEPTH(256), .READ_LATENCY(1), .WRITE_MODE(WM_WRITE_FIRST)) u0 (
    .clk(clk), .rst(rst), .wr_en_i(wr_en), .wr_be_i(wr_be), .wr_addr_i(wr_addr),
    .wr_data_i(wr_data), .rd_en_i(rd_en), .rd_addr_i(rd_addr),
    .rd_data_o(dd[0]), .rd_valid_o(vv[0]), .rd_perr_o(pp[0]));

  sdpram_bw #(.DATA_DEPTH(256), .READ_LATENCY(2), .WRITE_MODE(WM_READ_FIRST)) u1 (
    .clk(clk), .rst(rst), .wr_en_i(wr_en), .wr_be_i(wr_be), .wr_addr_i(wr_addr),
    .wr_data_i(wr_data), .rd_en_i(rd_en), .rd_addr_i(rd_addr),
    .rd_data_o(dd[1]), .rd_valid_o(vv[1]), .rd_perr_o(pp[1]));

  sdpram_bw #(.DATA_DEPTH(200), .READ_LATENCY(3), .WRITE_MODE(WM_WRITE_FIRST)) u2 (
    .clk(clk), .rst(rst), .wr_en_i(wr_en), .wr_be_i(wr_be), .wr_addr_i(wr_addr),
    .wr_data_i(wr_data), .rd_en_i(rd_en), .rd_addr_i(rd_addr),
    .rd_data_o(dd[2]), .rd_valid_o(vv[2]), .rd_perr_o(pp[2]));

  // Model: every accepted read is booked into the cycle it must appear in; reset wipes bookings.
  logic [31:0] mmem [NI][256];
  bit   [3:0]  mbad [NI][256];
  bit          ev   [NI][NC];
  logic [31:0] ed   [NI][NC];
  bit          ep   [NI][NC];
  logic [31:0] xd [NI];
  bit          xv [NI];
  bit          xp [NI];
  int          cyc = 0;
  bit          chk_en = 1'b0;

  always @(posedge clk) begin
    logic [31:0] m, w;
    logic [3:0]  bad;
    cyc++;
    m = {{8{wr_be[3]}}, {8{wr_be[2]}}, {8{wr_be[1]}}, {8{wr_be[0]}}};
    for (int i = 0; i < NI; i++) begin
      if (rst) begin
        for (int k = 0; k < 4; k++) ev[i][cyc+k] = 1'b0;
        xv[i] = 1'b0;
        xd[i] = '0;
        xp[i] = 1'b0;
      end else begin
        if (rd_en) begin
          if (rd_addr >= DEP[i]) begin
            w = '0;
            bad = '0;
          end else begin
            w = mmem[i][rd_addr];
            bad = mbad[i][rd_addr];
            if (!RDF[i] && wr_en && wr_addr == rd_addr) begin
              w = (w & ~m) | (wr_data & m);
              bad = bad & ~wr_be;
            end
          end
          ev[i][cyc+RLS[i]-1] = 1'b1;
          ed[i][cyc+RLS[i]-1] = w;
          ep[i][cyc+RLS[i]-1] = PAR_EN && (bad != 0);
        end
        if (wr_en && wr_addr < DEP[i]) begin
          mmem[i][wr_addr] = (mmem[i][wr_addr] & ~m) | (wr_data & m);
          mbad[i][wr_addr] = mbad[i][wr_addr] & ~wr_be;
        end
        xv[i] = ev[i][cyc];
        if (xv[i]) begin
          xd[i] = ed[i][cyc];
          xp[i] = ep[i][cyc];
        end else begin
          xp[i] = 1'b0;
        end
      end
    end
    if (rst) chk_en = 1'b1;
  end

  always @(negedge clk) begin
    if (chk_en) begin
      for (int i = 0; i < NI; i++) begin
        checks++;
        if (vv[i] !== xv[i] || pp[i] !== xp[i] || dd[i] !== xd[i]) begin
          errors++;
          $display("FAIL model u%0d cyc %0d: got v=%0b d=%h p=%0b, want v=%0b d=%h p=%0b",
                   i, cyc, vv[i], dd[i], pp[i], xv[i], xd[i], xp[i]);
        end
      end
    end
  end

  task automatic lit(input string nm, input int i, input bit v, input logic [31:0] d,
                     input bit use_d);
    checks++;
    if (vv[i] !== v || (use_d && dd[i] !== d)) begin
      errors++;
      $display("FAIL %s u%0d: got valid=%0b data=%h, want valid=%0b data=%h",
               nm, i, vv[i], dd[i], v, d);
    end
  endtask

  task automatic wr(input logic [7:0] a, input logic [31:0] d, input logic [3:0] be);
    wr_en = 1'b1; wr_addr = a; wr_data = d; wr_be = be;
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  // wmode: 0 none, 1 write on the read edge, 2 write on the edge after the read
  task automatic lit_read(input logic [7:0] a, input logic [31:0] e0, e1, e2, input int wmode,
                          input logic [7:0] wa, input logic [31:0] wd, input logic [3:0] wb);
    logic [31:0] e [NI];
    e[0] = e0; e[1] = e1; e[2] = e2;
    rd_en = 1'b1; rd_addr = a;
    if (wmode == 1) begin wr_en = 1'b1; wr_addr = wa; wr_data = wd; wr_be = wb; end
    @(negedge clk);
    rd_en = 1'b0; wr_en = 1'b0;
    if (wmode == 2) begin wr_en = 1'b1; wr_addr = wa; wr_data = wd; wr_be = wb; end
    for (int c = 1; c <= 3; c++) begin
      for (int i = 0; i < NI; i++) begin
        if (RLS[i] == c)     lit("rd_data", i, 1'b1, e[i], 1'b1);
        else if (RLS[i] > c) lit("rd_early", i, 1'b0, '0, 1'b0);
        else                 lit("rd_hold", i, 1'b0, e[i], 1'b1);
      end
      if (c < 3) begin
        @(negedge clk);
        wr_en = 1'b0;
      end
    end
  endtask

  initial begin
    repeat (3) @(negedge clk);
    rst = 1'b0;
    for (int n = 0; n < 10; n++) begin
      for (int i = 0; i < NI; i++) lit("reset_idle", i, 1'b0, '0, 1'b1);
      @(negedge clk);
    end

    wr(8'd5, 32'hDEADBEEF, 4'b1111);
    wr(8'd5, 32'h11223344, 4'b0101);
    lit_read(8'd5, 32'hDE22BE44, 32'hDE22BE44, 32'hDE22BE44, 0, '0, '0, '0);
    lit_read(8'd5, 32'hDE22BE44, 32'hDE22BE44, 32'hDE22BE44, 2, 8'd5, 32'h0, 4'hF);
    lit_read(8'd5, 32'h0, 32'h0, 32'h0, 0, '0, '0, '0);
    wr(8'd5, 32'hFFFFFFFF, 4'b0000);
    lit_read(8'd5, 32'h0, 32'h0, 32'h0, 0, '0, '0, '0);

    wr(8'd7, 32'hAAAAAAAA, 4'b1111);
    lit_read(8'd7, 32'hAAAA5555, 32'hAAAAAAAA, 32'hAAAA5555, 1, 8'd7, 32'h55555555, 4'b0011);
    lit_read(8'd7, 32'hAAAA5555, 32'hAAAA5555, 32'hAAAA5555, 0, '0, '0, '0);

    wr(8'd199, 32'hCAFEF00D, 4'hF);
    wr(8'd210, 32'h12345678, 4'hF);
    lit_read(8'd210, 32'h12345678, 32'h12345678, 32'h0, 0, '0, '0, '0);
    lit_read(8'd199, 32'hCAFEF00D, 32'hCAFEF00D, 32'hCAFEF00D, 0, '0, '0, '0);

    for (int a = 0; a < 8; a++) wr(8'(a), 32'(a * 3), 4'hF);
    for (int k = 0; k < 8; k++) begin
      rd_en = 1'b1; rd_addr = 8'(k); rst = (k >= 6);
      if (k == 7) begin wr_en = 1'b1; wr_addr = 8'd3; wr_data = '1; wr_be = 4'hF; end
      @(negedge clk);
      wr_en = 1'b0;
      if (k < 6) lit("b2b_rl1", 0, 1'b1, 32'(3 * k), 1'b1);
      else       lit("b2b_rst", 0, 1'b0, '0, 1'b1);
      if (k >= 1 && k < 6) lit("b2b_rl2", 1, 1'b1, 32'(3 * (k - 1)), 1'b1);
      else if (k >= 6)     lit("b2b_rst", 1, 1'b0, '0, 1'b1);
      if (k >= 2 && k < 6) lit("b2b_rl3", 2, 1'b1, 32'(3 * (k - 2)), 1'b1);
      else if (k >= 6)     lit("b2b_rst", 2, 1'b0, '0, 1'b1);
    end
    rd_en = 1'b0; rst = 1'b0;
    repeat (3) begin
      @(negedge clk);
      for (int i = 0; i < NI; i++) lit("post_rst", i, 1'b0, '0, 1'b1);
    end
    lit_read(8'd3, 32'd9, 32'd9, 32'd9, 0, '0, '0, '0);

`ifdef SDPRAM_PARITY_EN
    wr(8'd9, 32'h0F0F0F0F, 4'hF);
    wr(8'd10, 32'h01020304, 4'hF);
    u0.mem_q[9] = u0.mem_q[9] ^ 32'h1;
    mmem[0][9] = mmem[0][9] ^ 32'h1;
    mbad[0][9] = mbad[0][9] | 4'b0001;
    rd_en = 1'b1; rd_addr = 8'd9;
    @(negedge clk);
    rd_en = 1'b0;
    lit("perr_data", 0, 1'b1, 32'h0F0F0F0E, 1'b1);
    checks++;
    if (pp[0] !== 1'b1) begin
      errors++;
      $display("FAIL perr_flip u0: got perr=%0b, want perr=1", pp[0]);
    end
    rd_en = 1'b1; rd_addr = 8'd10;
    @(negedge clk);
    rd_en = 1'b0;
    checks++;
    if (pp[0] !== 1'b0 || vv[0] !== 1'b1) begin
      errors++;
      $display("FAIL perr_clean u0: got valid=%0b perr=%0b, want valid=1 perr=0", vv[0], pp[0]);
    end
`endif

    repeat (4) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
